// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder
//   Multi-cycle adder/subtractor. Each RUN cycle adds one CHUNK-bit slice
//   of the operands and ripples the slice carry to the next cycle through
//   a carry register. The full carry chain is therefore spread over N clocks.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for an operation; the accepting edge latches operands
//   RUN   | one slice per edge, k = 0 .. N-1
//   DONE  | result held on S/C_OUT/OVF until OUT_READY is seen
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   IN_VALID / IN_READY   operand handshake
//   SUB, C0, X, Y         mode, add-mode carry-in, operands
//   OUT_VALID / OUT_READY result handshake
//   S, C_OUT, OVF         sum/difference, unsigned carry (1 = no borrow in
//                         SUB mode), signed overflow
module pipelined_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             SUB,
    input  logic             C0,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             C_OUT,
    output logic             OVF
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // already inverted for subtraction
    logic             carry;
    logic [KW-1:0]    k;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] sum_slice;
    logic             ripple_c;
    logic             slice_cout;
    logic             slice_cmsb; // carry into the top bit of the slice

    // Select the active slice of the latched operands.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int j = 0; j < N; j++) begin
            if (k == KW'(j)) begin
                a_slice = a_reg[j*CHUNK +: CHUNK];
                b_slice = b_reg[j*CHUNK +: CHUNK];
            end
        end
    end

    // Ripple of full-adder cells across the slice. On the last slice the
    // carry into its top bit is the carry into the operand MSB.
    always_comb begin
        sum_slice  = '0;
        ripple_c   = carry;
        slice_cmsb = carry;
        slice_cout = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            slice_cmsb   = ripple_c;
            sum_slice[i] = a_slice[i] ^ b_slice[i] ^ ripple_c;
            ripple_c     = (a_slice[i] & b_slice[i]) |
                           (ripple_c & (a_slice[i] ^ b_slice[i]));
        end
        slice_cout = ripple_c;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            S         <= '0;
            C_OUT     <= 1'b0;
            OVF       <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        a_reg    <= X;
                        b_reg    <= SUB ? ~Y : Y;
                        carry    <= SUB | C0;   // SUB forces the +1 of two's complement
                        k        <= '0;
                        IN_READY <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int j = 0; j < N; j++) begin
                        if (k == KW'(j)) begin
                            S[j*CHUNK +: CHUNK] <= sum_slice;
                        end
                    end
                    carry <= slice_cout;
                    if (k == K_LAST) begin
                        C_OUT     <= slice_cout;
                        OVF       <= slice_cmsb ^ slice_cout;
                        OUT_VALID <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pipelined_chunk_adder.md
Name: pipelined_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor, successor of the team's 4-bit ripple full adder.
- Adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a carry register.
- Valid/ready handshakes on input and output, plus a subtract mode, carry-out and signed-overflow flags.
- Sits between operand producers and ALU consumers where one wide combinational carry chain would break timing.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock (ripple slice width); 1 <= CHUNK <= WIDTH.
- N (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operands and mode are valid.
- IN_READY  out  1  block can accept an operation.
- SUB  in  1  0: X + Y + C0; 1: X - Y, computed as X + ~Y + 1 with C0 ignored.
- C0  in  1  carry-in for add mode.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- OUT_VALID  out  1  result is valid.
- OUT_READY  in  1  consumer accepts the result.
- S  out  WIDTH  sum/difference.
- C_OUT  out  1  carry out of the MSB; in SUB mode 1 = no borrow.
- OVF  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE; IN_READY=1; OUT_VALID=0; S=0; C_OUT=0; OVF=0.
  - Chunk counter, carry register and latched operands cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - IN_READY=1, OUT_VALID=0.
  - On an edge with IN_VALID=1, latch X, Y (or ~Y if SUB=1).
  - Initial carry = SUB ? 1 : C0.
  - Chunk index k=0; go to RUN.
  - IN_VALID=0: stay IDLE.
- RUN:
  - IN_READY=0, OUT_VALID=0.
  - Each edge computes bits [k*CHUNK +: CHUNK] as a ripple of full-adder cells from the carry register, writes that S slice, and updates the carry register to the slice carry-out.
  - On the last chunk (k=N-1), also capture the carry into the MSB for OVF, set C_OUT, and go to DONE.
  - Otherwise k increments.
  - Operand inputs are ignored during RUN.
- Latency: OUT_VALID rises exactly N clocks after the accepting edge.
- DONE:
  - OUT_VALID=1, IN_READY=0.
  - S, C_OUT and OVF are held stable while OUT_READY=0, for any number of cycles (backpressure).
  - On an edge with OUT_READY=1, go to IDLE. IN_READY becomes 1 the next cycle, so throughput is one operation per N+2 cycles.
- S is updated slice by slice during RUN and is valid only while OUT_VALID=1. Upper bits hold stale data mid-operation.
- Width rules:
  - All arithmetic is modulo 2^WIDTH. No sign extension.
  - OVF is meaningful for signed interpretation; C_OUT for unsigned.
- CHUNK=WIDTH (N=1): a single RUN cycle; same state sequence.
- Signals changing during RUN/DONE: IN_VALID asserted has no effect, and no operation is queued.
- OUT_READY held high in IDLE/RUN: no effect.
- Reset mid-RUN or in DONE: the operation is abandoned, all outputs take their reset values, and no OUT_VALID pulse is produced.
- X/Y/SUB/C0 only need to be stable at the accepting edge.

Test Plan:
- WIDTH=16, CHUNK=4, add, X=0xFFFF, Y=0x0001, C0=0 -> after 4 clocks OUT_VALID=1, S=0x0000, C_OUT=1, OVF=0.
- Add, X=0x7FFF, Y=0x0001, C0=0 -> S=0x8000, C_OUT=0, OVF=1. Repeat with X=0x1234, Y=0x4321, C0=1 -> S=0x5556, C_OUT=0, OVF=0.
- SUB=1, X=0x0005, Y=0x0007 -> S=0xFFFE, C_OUT=0 (borrow), OVF=0. SUB=1, X=0x8000, Y=0x0001 -> S=0x7FFF, C_OUT=1, OVF=1.
- Backpressure: hold OUT_READY=0 for 10 cycles after OUT_VALID, toggle X/Y/IN_VALID -> S/flags unchanged and IN_READY=0. Then OUT_READY=1 for one edge -> IDLE, IN_READY=1 next cycle.
- Assert RST asynchronously at RUN cycle 2 -> outputs zero immediately, IN_READY=1. A following op X=0x00FF, Y=0x0001 -> S=0x0100 with normal latency.
- Sweep (WIDTH, CHUNK) = (8,8), (8,1), (32,4) with 1000 random back-to-back ops -> S/C_OUT/OVF match a reference model and latency = N every time.
